// File: rtl/regfile_dbg_master_if.sv
// Debug transport request/response channel for regfile_dbg_master.
// The slave modport is the register-file debug initiator; master is the transport.
interface regfile_dbg_master_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [1:0]        req_op_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_data_i;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic [DATA_W-1:0] resp_data_o;
    logic              resp_err_o;

    modport slave (
        input  req_valid_i, req_op_i, req_addr_i, req_data_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_err_o
    );

    modport master (
        output req_valid_i, req_op_i, req_addr_i, req_data_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_err_o
    );
endinterface

// File: rtl/regfile_dbg_master.sv
// Debug initiator for the register file JTAG port: one command, one response, bounded write retry.
// Optional build macro DBG_READBACK_EN adds a VERIFY readback after each successful write.
module regfile_dbg_master #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_RETRY = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_dbg_master_if.slave  bus,
    input  logic                 core_w_en_i,
    input  logic [ADDR_W-1:0]    core_w_addr_i,
    output logic [ADDR_W-1:0]    jtag_addr_o,
    output logic                 w_jtag_en_o,
    output logic [DATA_W-1:0]    w_jtag_data_o,
    input  logic [DATA_W-1:0]    r_jtag_data_i
);

    localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
    localparam logic [RetryW-1:0] MaxRetryC = RetryW'(MAX_RETRY);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
`ifdef DBG_READBACK_EN
        StVerify,
`endif
        StResp
    } state_e;

    state_e            r_state;
    state_e            w_next_state;
    logic [ADDR_W-1:0] r_jtag_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [RetryW-1:0] r_retry;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_err;
    logic              w_req_fire;
    logic              w_collision;
    logic              w_retry_max;

    // The core owns the register file port on a same-address write, so our write is lost.
    assign w_collision = core_w_en_i && (core_w_addr_i == r_jtag_addr) && (r_jtag_addr != '0);
    assign w_retry_max = (r_retry == MaxRetryC);
    assign w_req_fire  = (r_state == StIdle) && bus.req_valid_i;

    assign jtag_addr_o     = r_jtag_addr;
    assign w_jtag_data_o   = r_wdata;
    assign bus.resp_data_o = r_resp_data;
    assign bus.resp_err_o  = r_resp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            StIdle: begin
                if (w_req_fire) begin
                    case (bus.req_op_i)
                        2'b01:   w_next_state = StRead;
                        2'b10:   w_next_state = StWrite;
                        default: w_next_state = StResp;
                    endcase
                end
            end
            StRead: w_next_state = StResp;
            StWrite: begin
                if (w_collision) begin
                    if (w_retry_max) begin
                        w_next_state = StResp;
                    end
                end else begin
`ifdef DBG_READBACK_EN
                    w_next_state = StVerify;
`else
                    w_next_state = StResp;
`endif
                end
            end
`ifdef DBG_READBACK_EN
            StVerify: w_next_state = StResp;
`endif
            StResp: begin
                if (bus.resp_ready_i) begin
                    w_next_state = StIdle;
                end
            end
            default: w_next_state = StIdle;
        endcase
    end

    always_comb begin
        bus.req_ready_o  = (r_state == StIdle);
        bus.resp_valid_o = (r_state == StResp);
        w_jtag_en_o      = (r_state == StWrite);
    end

    // Address and write data only change when a new access starts, so they hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_jtag_addr <= '0;
            r_wdata     <= '0;
            r_retry     <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_req_fire) begin
                        case (bus.req_op_i)
                            2'b01: r_jtag_addr <= bus.req_addr_i;
                            2'b10: begin
                                r_jtag_addr <= bus.req_addr_i;
                                r_wdata     <= bus.req_data_i;
                                r_retry     <= '0;
                            end
                            default: begin
                                r_resp_data <= '0;
                                r_resp_err  <= 1'b1;
                            end
                        endcase
                    end
                end
                StRead: begin
                    r_resp_data <= r_jtag_data_i;
                    r_resp_err  <= 1'b0;
                end
                StWrite: begin
                    if (w_collision) begin
                        if (w_retry_max) begin
                            r_resp_data <= '0;
                            r_resp_err  <= 1'b1;
                        end else begin
                            r_retry <= r_retry + 1'b1;
                        end
                    end else begin
`ifndef DBG_READBACK_EN
                        r_resp_data <= '0;
                        r_resp_err  <= 1'b0;
`endif
                    end
                end
`ifdef DBG_READBACK_EN
                StVerify: begin
                    r_resp_data <= r_jtag_data_i;
                    r_resp_err  <= (r_jtag_data_i != r_wdata);
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dbg_master.sv
// Randomized self-checking bench for regfile_dbg_master with a behavioural register file.
// Expectations come from a command-level model (latency, retry budget, shadow register contents).
module tb_regfile_dbg_master;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int MaxRetry = 4;
`ifdef DBG_READBACK_EN
    localparam bit Rb = 1'b1;
`else
    localparam bit Rb = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          core_w_en = 1'b0;
    logic [AW-1:0] core_w_addr = '0;
    logic [DW-1:0] core_w_data = '0;
    logic [AW-1:0] jtag_addr;
    logic          w_jtag_en;
    logic [DW-1:0] w_jtag_data;
    logic [DW-1:0] r_jtag_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mem [32] = '{default: '0};
    logic [DW-1:0] shadow [32];

    regfile_dbg_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    regfile_dbg_master #(.ADDR_W(AW), .DATA_W(DW), .MAX_RETRY(MaxRetry)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .core_w_en_i   (core_w_en),
        .core_w_addr_i (core_w_addr),
        .jtag_addr_o   (jtag_addr),
        .w_jtag_en_o   (w_jtag_en),
        .w_jtag_data_o (w_jtag_data),
        .r_jtag_data_i (r_jtag_data)
    );

    always #5 clk = ~clk;

    // Register file: core port wins on a same-address write, x0 is hard-wired to zero.
    assign r_jtag_data = mem[jtag_addr];
    always @(posedge clk) begin
        if (core_w_en && core_w_addr != '0) mem[core_w_addr] <= core_w_data;
        if (w_jtag_en && jtag_addr != '0 && !(core_w_en && core_w_addr == jtag_addr))
            mem[jtag_addr] <= w_jtag_data;
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int ncoll, input int stall);
        bit            is_rd, is_wr, fail;
        int            nc, wcyc, cyc, wen_cnt, exp_lat;
        logic [DW-1:0] exp_data;
        logic          exp_err;
        is_rd   = (op == 2'b01);
        is_wr   = (op == 2'b10);
        nc      = (is_wr && a != '0) ? ncoll : 0;
        fail    = nc > MaxRetry;
        wcyc    = (fail ? MaxRetry : nc) + 1;
        wen_cnt = 0;
        cyc     = 0;

        @(negedge clk);
        check_eq("req_ready_idle", bus.req_ready_o, 1'b1);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_addr_i  = a;
        bus.req_data_i  = d;
        @(negedge clk);
        bus.req_valid_i = 1'b0;

        while (bus.resp_valid_o !== 1'b1 && cyc < 20) begin
            core_w_en   = (cyc < nc);
            core_w_addr = a;
            core_w_data = $urandom;
            if (cyc < nc) shadow[a] = core_w_data;
            if (w_jtag_en) begin
                wen_cnt++;
                check_eq("wr_addr", jtag_addr, a);
                check_eq("wr_data", w_jtag_data, d);
            end
            if (is_rd && cyc == 0) check_eq("rd_addr", jtag_addr, a);
            cyc++;
            @(negedge clk);
        end
        core_w_en = 1'b0;
        if (cyc >= 20) begin
            check_eq("resp_timeout", 32'd0, 32'd1);
            bus.resp_ready_i = 1'b1;
            @(negedge clk);
            bus.resp_ready_i = 1'b0;
            return;
        end

        if (is_wr && !fail && a != '0) shadow[a] = d;
        if (is_rd) begin
            exp_data = (a == '0) ? '0 : shadow[a];
            exp_err  = 1'b0;
            exp_lat  = 1;
        end else if (is_wr) begin
            exp_lat = wcyc + ((Rb && !fail) ? 1 : 0);
            if (fail) begin
                exp_data = '0;
                exp_err  = 1'b1;
            end else if (Rb) begin
                exp_data = (a == '0) ? '0 : d;
                exp_err  = (exp_data != d);
            end else begin
                exp_data = '0;
                exp_err  = 1'b0;
            end
        end else begin
            exp_data = '0;
            exp_err  = 1'b1;
            exp_lat  = cyc;
        end
        if (is_rd || is_wr) check_eq("latency", cyc, exp_lat);
        check_eq("wen_cycles", wen_cnt, is_wr ? wcyc : 0);

        for (int s = 0; s < stall; s++) begin
            check_eq("stall_valid", bus.resp_valid_o, 1'b1);
            check_eq("stall_data", bus.resp_data_o, exp_data);
            check_eq("stall_err", bus.resp_err_o, exp_err);
            check_eq("stall_ready", bus.req_ready_o, 1'b0);
            bus.req_valid_i = 1'b1;
            bus.req_op_i    = 2'b01;
            @(negedge clk);
        end
        bus.req_valid_i  = 1'b0;
        check_eq("resp_valid", bus.resp_valid_o, 1'b1);
        check_eq("resp_data", bus.resp_data_o, exp_data);
        check_eq("resp_err", bus.resp_err_o, exp_err);
        check_eq("resp_wen", w_jtag_en, 1'b0);
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        bus.resp_ready_i = 1'b0;
        check_eq("post_valid", bus.resp_valid_o, 1'b0);
        check_eq("post_ready", bus.req_ready_o, 1'b1);
    endtask

    initial begin
        int r;
        logic [1:0] op;
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        bus.req_valid_i  = 1'b0;
        bus.req_op_i     = 2'b00;
        bus.req_addr_i   = '0;
        bus.req_data_i   = '0;
        bus.resp_ready_i = 1'b0;

        #1;
        check_eq("rst_req_ready", bus.req_ready_o, 1'b1);
        check_eq("rst_resp_valid", bus.resp_valid_o, 1'b0);
        check_eq("rst_resp_data", bus.resp_data_o, '0);
        check_eq("rst_resp_err", bus.resp_err_o, 1'b0);
        check_eq("rst_jtag_addr", jtag_addr, '0);
        check_eq("rst_wen", w_jtag_en, 1'b0);
        check_eq("rst_wdata", w_jtag_data, '0);
        @(negedge clk);
        rst_n = 1'b1;

        do_cmd(2'b10, 5'd5, 32'hDEADBEEF, 0, 0);
        do_cmd(2'b01, 5'd5, 32'h0, 0, 0);
        do_cmd(2'b11, 5'd7, 32'hAAAA5555, 0, 0);
        do_cmd(2'b10, 5'd9, 32'h1234, 2, 0);
        do_cmd(2'b01, 5'd9, 32'h0, 0, 0);
        do_cmd(2'b10, 5'd9, 32'h5678, MaxRetry + 1, 0);
        do_cmd(2'b01, 5'd9, 32'h0, 0, 0);
        do_cmd(2'b01, 5'd5, 32'h0, 0, 5);
        do_cmd(2'b10, 5'd0, 32'h1, 0, 0);
        do_cmd(2'b01, 5'd0, 32'h0, 0, 0);

        // Reset while a write is retrying against a colliding core write.
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = 2'b10;
        bus.req_addr_i  = 5'd9;
        bus.req_data_i  = 32'h5555;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        core_w_en       = 1'b1;
        core_w_addr     = 5'd9;
        core_w_data     = 32'h77;
        check_eq("mid_wen", w_jtag_en, 1'b1);
        #2;
        rst_n     = 1'b0;
        core_w_en = 1'b0;
        #1;
        check_eq("arst_wen", w_jtag_en, 1'b0);
        check_eq("arst_valid", bus.resp_valid_o, 1'b0);
        check_eq("arst_ready", bus.req_ready_o, 1'b1);
        check_eq("arst_addr", jtag_addr, '0);
        check_eq("arst_wdata", w_jtag_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("post_rst_valid", bus.resp_valid_o, 1'b0);
            check_eq("post_rst_ready", bus.req_ready_o, 1'b1);
        end

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      op = 2'b01;
            else if (r < 8) op = 2'b10;
            else            op = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
            do_cmd(op, AW'($urandom_range(0, 31)), $urandom,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, MaxRetry + 1) : 0,
                   $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
